// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops, iterative shift-add multiply
// and restoring divide, results and NZCV flags held until the consumer takes them.
module alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             AddSubCBin,
  input  logic [3:0]       ALU_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       FlagsNZCV
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned LOG_W = $clog2(WIDTH);
  localparam int unsigned W1    = WIDTH + 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_MULU = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_MOD  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_EOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LSL  = 4'hA;
  localparam logic [3:0] OP_LSR  = 4'hB;
  localparam logic [3:0] OP_ASR  = 4'hC;
  localparam logic [3:0] OP_ROR  = 4'hD;
  localparam logic [3:0] OP_PASS = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIVD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [3:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [3:0]           flags_q, flags_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  // One shift-add multiply step: accumulate A into the high half on multiplier LSB, shift right.
  logic [WIDTH:0]       madd;
  logic [2*WIDTH-1:0]   mul_next;
  assign madd     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : W1'(0));
  assign mul_next = {madd, prod_q[WIDTH-1:1]};

  // One restoring divide step over {remainder, quotient}; B=0 naturally yields all-ones / A.
  logic [WIDTH:0]       drem, ddiff;
  logic [2*WIDTH-1:0]   div_next;
  assign drem     = prod_q[2*WIDTH-1:WIDTH-1];
  assign ddiff    = drem - {1'b0, b_q};
  assign div_next = ddiff[WIDTH] ? {drem[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                 : {ddiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  // Single-cycle datapath evaluated on the accepted inputs.
  logic [WIDTH:0]         sum_w;
  logic [WIDTH-1:0]       res_f, res_o;
  logic signed [WIDTH-1:0] asr_v;
  logic [2*WIDTH-1:0]     rot_v;
  logic [LOG_W-1:0]       sh;
  logic                   big_sh, c1, v1;

  always_comb begin
    sum_w  = '0;
    res_f  = '0;
    c1     = 1'b0;
    v1     = 1'b0;
    sh     = B_in[LOG_W-1:0];
    big_sh = (B_in >= WIDTH'(WIDTH));
    asr_v  = $signed(A_in) >>> sh;
    rot_v  = {A_in, A_in} >> sh;
    case (ALU_op)
      OP_ADD: begin
        sum_w = {1'b0, A_in} + {1'b0, B_in} + W1'(AddSubCBin);
        res_f = sum_w[WIDTH-1:0];
        c1    = sum_w[WIDTH];
        v1    = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (res_f[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sum_w = {1'b0, A_in} - {1'b0, B_in} - W1'(AddSubCBin);
        res_f = sum_w[WIDTH-1:0];
        c1    = sum_w[WIDTH];
        v1    = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (res_f[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_AND:  res_f = A_in & B_in;
      OP_OR:   res_f = A_in | B_in;
      OP_EOR:  res_f = A_in ^ B_in;
      OP_NOT:  res_f = ~A_in;
      OP_LSL:  res_f = big_sh ? '0 : (A_in << sh);
      OP_LSR:  res_f = big_sh ? '0 : (A_in >> sh);
      OP_ASR:  res_f = big_sh ? {WIDTH{A_in[WIDTH-1]}} : asr_v;
      OP_ROR:  res_f = rot_v[WIDTH-1:0];
      OP_PASS: res_f = A_in;
      default: res_f = '0;
    endcase
    res_o = (ALU_op == OP_CMP) ? '0 : res_f;
  end

  // Next-state and datapath register updates.
  logic [WIDTH-1:0] res_m;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    prod_d  = prod_q;
    out_d   = out_q;
    flags_d = flags_q;
    res_m   = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d  = A_in;
          b_d  = B_in;
          op_d = ALU_op;
          if (ALU_op == OP_MUL || ALU_op == OP_MULU) begin
            prod_d  = {{WIDTH{1'b0}}, B_in};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_MULT;
          end else if (ALU_op == OP_DIV || ALU_op == OP_MOD) begin
            prod_d  = {{WIDTH{1'b0}}, A_in};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_DIVD;
          end else begin
            out_d   = res_o;
            flags_d = {res_f[WIDTH-1], (res_f == '0), c1, v1};
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_MULT: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_m   = (op_q == OP_MULU) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
          out_d   = res_m;
          flags_d = {res_m[WIDTH-1], (res_m == '0),
                     (op_q == OP_MUL) && (mul_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
          state_d = S_DONE;
        end
      end
      S_DIVD: begin
        prod_d = div_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_m   = (op_q == OP_MOD) ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
          out_d   = res_m;
          flags_d = {res_m[WIDTH-1], (res_m == '0), 1'b0, (b_q == '0)};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      prod_q      <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign FlagsNZCV = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed vector bench for alu_multicycle: table of ops plus reset/back-pressure sequences.
module tb_alu_multicycle;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, AddSubCBin, out_valid, out_ready;
  logic [W-1:0] A_in, B_in, out;
  logic [3:0]   ALU_op, FlagsNZCV;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .AddSubCBin(AddSubCBin), .ALU_op(ALU_op),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .FlagsNZCV(FlagsNZCV)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_nzcv;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic void add(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic [W-1:0] eo, input logic [3:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin; v.exp_out = eo; v.exp_nzcv = ef;
    v.exp_lat = (op >= 4'h2 && op <= 4'h5) ? 17 : 1;
    vecs.push_back(v);
  endfunction

  // Issue one op, scramble inputs after accept, count cycles to out_valid, then take the result.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output logic [W-1:0] o, output logic [3:0] f,
                        output int lat, output logic busy_ok, output logic [1:0] hs_after);
    @(negedge clk);
    ALU_op = op; A_in = a; B_in = b; AddSubCBin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; A_in = 16'h5A5A; B_in = 16'h0003; AddSubCBin = 1'b1; ALU_op = 4'h0;
    busy_ok = !in_ready;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out; f = FlagsNZCV;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    hs_after = {in_ready, out_valid};
  endtask

  initial begin
    logic [W-1:0] o;
    logic [3:0]   f;
    int           lat;
    logic         busy_ok;
    logic [1:0]   hs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A_in = '0; B_in = '0; AddSubCBin = 1'b0; ALU_op = '0;

    add(4'h0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001);
    add(4'h0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0110);
    add(4'h0, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000);
    add(4'h1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1010);
    add(4'h1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 4'b0000);
    add(4'h2, 16'h1234, 16'h0100, 1'b0, 16'h3400, 4'b0010);
    add(4'h3, 16'h1234, 16'h0100, 1'b0, 16'h0012, 4'b0000);
    add(4'h2, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 4'b0010);
    add(4'h3, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b1000);
    add(4'h4, 16'h0064, 16'h0007, 1'b0, 16'h000E, 4'b0000);
    add(4'h5, 16'h0064, 16'h0007, 1'b0, 16'h0002, 4'b0000);
    add(4'h4, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 4'b1001);
    add(4'h5, 16'h1234, 16'h0000, 1'b0, 16'h1234, 4'b0001);
    add(4'h6, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 4'b0000);
    add(4'h7, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 4'b1000);
    add(4'h8, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 4'b0100);
    add(4'h9, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 4'b1000);
    add(4'hD, 16'h8001, 16'd1,    1'b0, 16'hC000, 4'b1000);
    add(4'hD, 16'h8001, 16'd17,   1'b0, 16'hC000, 4'b1000);
    add(4'hD, 16'h8001, 16'd0,    1'b0, 16'h8001, 4'b1000);
    add(4'hC, 16'h8000, 16'd20,   1'b0, 16'hFFFF, 4'b1000);
    add(4'hC, 16'h8000, 16'd4,    1'b0, 16'hF800, 4'b1000);
    add(4'hA, 16'h8001, 16'd16,   1'b0, 16'h0000, 4'b0100);
    add(4'hA, 16'h0001, 16'd15,   1'b0, 16'h8000, 4'b1000);
    add(4'hB, 16'h8000, 16'd15,   1'b0, 16'h0001, 4'b0000);
    add(4'hB, 16'h8000, 16'd16,   1'b0, 16'h0000, 4'b0100);
    add(4'hE, 16'h8000, 16'h1111, 1'b0, 16'h8000, 4'b1000);
    add(4'hF, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0100);
    add(4'hF, 16'h0003, 16'h0005, 1'b0, 16'h0000, 4'b1010);
    add(4'hF, 16'h8000, 16'h0001, 1'b0, 16'h0000, 4'b0001);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check("reset_out", 32'(out), 32'h0);
    check("reset_flags", 32'(FlagsNZCV), 32'h0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, o, f, lat, busy_ok, hs);
      check($sformatf("v%0d_op%0h_out", i, vecs[i].op), 32'(o), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_op%0h_nzcv", i, vecs[i].op), 32'(f), 32'(vecs[i].exp_nzcv));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy_not_ready", i), 32'(busy_ok), 32'h1);
      check($sformatf("v%0d_idle_after_take", i), 32'(hs), 32'b10);
    end

    // Back-pressure: result and flags held while consumer stalls.
    @(negedge clk);
    ALU_op = 4'h1; A_in = 16'h0000; B_in = 16'h0001; AddSubCBin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A_in = 16'h7777; B_in = 16'h7777;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_out", k), 32'(out), 32'hFFFF);
      check($sformatf("bp%0d_nzcv", k), 32'(FlagsNZCV), 32'b1010);
      check($sformatf("bp%0d_hs", k), {30'd0, in_ready, out_valid}, 32'b01);
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_hs", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    ALU_op = 4'h2; A_in = 16'h1234; B_in = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rstmul_hs", {30'd0, in_ready, out_valid}, 32'b10);
    check("rstmul_out", 32'(out), 32'h0);
    check("rstmul_flags", 32'(FlagsNZCV), 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstmul_no_stray_valid", {30'd0, in_ready, out_valid}, 32'b10);
    run_op(4'h0, 16'h7FFF, 16'h0001, 1'b0, o, f, lat, busy_ok, hs);
    check("post_rst_add_out", 32'(o), 32'h8000);
    check("post_rst_add_nzcv", 32'(f), 32'b1001);
    check("post_rst_add_latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked successor to the single-cycle datapath ALU. Arithmetic, logic, shift and rotate operations complete in one cycle. MUL/MULU use iterative shift-add and DIV/MOD use restoring division, so no wide combinational multiplier or divider is inferred. The block sits between register-file read and writeback and gives results and NZCV flags through a valid/ready pair.

## Interface
- WIDTH, 16: operand/result width; power of two, ≥4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- A_in  in  WIDTH  operand A.
- B_in  in  WIDTH  operand B / shift amount.
- AddSubCBin  in  1  carry/borrow in, ADD/SUB only.
- ALU_op  in  4  opcode (below).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result, registered.
- FlagsNZCV  out  4  {N,Z,C,V}, registered.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 MUL (low word)
  - 0011 MULU (high word, unsigned)
  - 0100 DIV (unsigned)
  - 0101 MOD (unsigned)
  - 0110 AND
  - 0111 OR
  - 1000 EOR
  - 1001 NOT A
  - 1010 LSL
  - 1011 LSR
  - 1100 ASR
  - 1101 ROR
  - 1110 pass A
  - 1111 CMP
- States:
  - IDLE → accept on in_valid&in_ready, latching A, B, cin and op.
  - Single-cycle ops go to DONE. MUL/MULU go to MULT. DIV/MOD go to DIVD, with counter=WIDTH.
  - MULT/DIVD: one bit step per cycle, counter decrements; at the step where counter reaches 0, go to DONE.
  - DONE: out_valid=1. out/flags hold stable until out_ready=1, then go to IDLE.
- ADD: {C,out}=A+B+cin (WIDTH+1 bits); V=(A[W-1]==B[W-1])&&(out[W-1]!=A[W-1]).
- SUB/CMP: out=A−B−cin; C=1 on borrow (A < B+cin unsigned); V=(A[W-1]!=B[W-1])&&(out[W-1]!=A[W-1]).
  - CMP drives out=0 but N/Z/C/V come from A−B−cin.
- MUL: full 2·WIDTH unsigned product P; out=P[W-1:0]; C=(P[2W-1:W]!=0); V=0.
- MULU: out=P[2W-1:W]; C=0; V=0.
- DIV: out=A/B. MOD: out=A%B. C=0.
  - B=0: DIV out=all ones, MOD out=A, V=1. Otherwise V=0.
- Shifts: amount s=B (full value).
  - LSL/LSR: s≥WIDTH → out=0.
  - ASR: s≥WIDTH → out = all copies of A[W-1].
- ROR: rotate right by B mod WIDTH. s=0 → out=A.
- Logic, NOT, shifts, rotate, pass: C=0, V=0.
- Flags for every non-CMP op: N=out[W-1]; Z=(out==0).
- Inputs are ignored when in_ready=0; operands are held internally, so upstream may change A_in/B_in after accept.

## Timing
- Reset (any state, including mid-iteration): next edge → IDLE, in_ready=1, out_valid=0, out=0, FlagsNZCV=0, counter=0. The in-flight op is discarded with no output.
- Single-cycle ops: accept at edge t → out_valid=1 from edge t+1.
- MUL/MULU/DIV/MOD: accept at edge t → out_valid=1 from edge t+WIDTH+1.
- Back-pressure: with out_ready=0, DONE holds indefinitely and out/flags do not change.
- Handshake:
  - out_valid&out_ready at edge u → IDLE; in_ready=1 from u.
  - Earliest next accept is edge u+1.
  - Max throughput: one single-cycle op per 2 cycles.
- in_ready and out_valid are never both 1.

## Test plan
- Reset mid-op: ADD 0x7FFF+0x0001, cin=0 → out=0x8000, NZCV=1001, one cycle after accept.
- Back-pressure: SUB 0x0000−0x0001, held out_ready=0 for 5 cycles → out=0xFFFF, NZCV=1010 stable throughout; IDLE one edge after ready.
- WIDTH=16 multiply: MUL 0x1234×0x0100 → out=0x3400, C=1, out_valid exactly 17 cycles after accept. MULU on the same operands → out=0x0012, C=0.
- Divide: DIV 0x0064/0x0007 → 0x000E. MOD → 0x0002. DIV by 0 with A=0x1234 → 0xFFFF, V=1. MOD by 0 → 0x1234, V=1.
- Shift/rotate with CMP:
  - ROR 0x8001 by 1 → 0xC000. ROR by 17 → same.
  - ASR 0x8000 by 20 → 0xFFFF. LSL by 16 → 0x0000, Z=1.
  - CMP 5,5 → out=0, Z=1. CMP 3,5 → N=1, C=1.
- Reset mid-MUL: assert rst at iteration 8 → next cycle in_ready=1, out_valid=0, out=0, flags=0. A new ADD then completes normally.
